instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the instruction decoder. Accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit Frost32 instruction words.
- Buffers the packed words in a small FIFO and streams them, each tagged with an incrementing word address, to an instruction-memory write port.
- Used by the program loader and by the test infrastructure to generate instruction streams.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- BASE_ADDR, 32'h0000_0000, address tagged on the first word after reset or flush; must be 4-byte aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear: empties the FIFO, reloads the address to BASE_ADDR, clears err_sticky.
- in_valid  in  1  input fields valid.
- in_ready  out  1  block can accept a word.
- in_group  in  4  instruction group.
- in_ra_index  in  4  ra field.
- in_rb_index  in  4  rb field.
- in_rc_index  in  4  rc field.
- in_opcode  in  4  opcode.
- in_imm_val  in  16  immediate value.
- out_valid  out  1  head word valid.
- out_ready  in  1  consumer takes the head word.
- out_data  out  32  encoded instruction word.
- out_addr  out  32  byte address of out_data.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- err_sticky  out  1  set when any accepted input was malformed.
- err_clr  in  1  clears err_sticky.

Behaviour:
- Reset (rst_n=0 at a clock edge): FIFO empty, count=0, out_valid=0, out_data=0, out_addr=BASE_ADDR, err_sticky=0, in_ready=1 from the next cycle.
- Encoding is combinational from the in_* fields. The word is written into the FIFO on push, where push = in_valid & in_ready.
- Bit layout: grp=[31:28], ra=[27:24], rb=[23:20].
  - Group 0 (three registers) and groups 3/4 (jumps): rc=[19:16], [15:4]=0, opcode=[3:0]. in_imm_val is ignored.
  - Groups 1/2 (immediates, branches): opcode=[19:16], imm16=[15:0]. in_rc_index is ignored.
  - Group 5 (load/store): rc=[19:16], opcode=[15:12], imm12=in_imm_val[11:0]. The input is malformed if in_imm_val[15:12] is not four copies of in_imm_val[11]; in that case the word is still encoded with the truncated value.
  - Groups 6..15: malformed; the emitted word is 32'h0 (NOP).
- err_sticky is set on a push of any malformed input. err_clr clears it. If a malformed push and err_clr occur in the same cycle, the set wins.
- in_ready = (count < DEPTH). It does not depend on out_ready, so there is no combinational path from out_ready to in_ready.
  - When full, push is blocked even if a pop occurs in the same cycle.
- out_valid = (count != 0). out_data is the head entry, driven from registers.
- Latency: a word pushed in cycle N is visible on out_data in cycle N+1 when the FIFO was empty.
- Pop = out_valid & out_ready. On pop, out_addr += 4, wrapping modulo 2^32 (FFFF_FFFC -> 0000_0000).
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Priority: rst_n > flush > push/pop. A push in the flush cycle is discarded.
  - Reset or flush in the middle of a stream discards buffered words; no partial state remains.
- out_data and out_addr are held stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: INSTR_ENCODER_DROP_BAD_EN.
- Defined: a malformed input is accepted (in_ready handshake completes) and sets err_sticky, but it is not written to the FIFO; count and out_addr are unaffected.
- Undefined: malformed inputs are written as described above (truncated imm12, or 32'h0 for groups 6..15).

Test Plan:
- Group 0, ra=1, rb=2, rc=3, op=5, then group 1, ra=4, rb=5, op=2, imm=BEEF, out_ready=1 -> 0x0123_0005 @ BASE_ADDR, then 0x1452_BEEF @ BASE_ADDR+4; err_sticky=0.
- Group 5, ra=1, rb=2, rc=3, op=6, imm=FFF8 -> 0x5123_6FF8, err_sticky=0. Same with imm=0800 -> 0x5123_6800 and err_sticky=1; assert err_clr -> 0.
- Group 9 with arbitrary fields -> 0x0000_0000 emitted and err_sticky=1. With INSTR_ENCODER_DROP_BAD_EN defined: nothing emitted, count stays 0.
- out_ready=0, push DEPTH+2 words -> in_ready falls after DEPTH pushes, count=DEPTH, out_data stable. Release out_ready -> all DEPTH words in order, addresses BASE_ADDR..BASE_ADDR+4*(DEPTH-1).
- Continuous push and pop at count=2 for 20 cycles -> count stays 2, ordering is preserved, and out_addr wraps correctly when BASE_ADDR=FFFF_FFF0.
- flush (and separately rst_n=0) with 3 words buffered -> next cycle count=0, out_valid=0, out_addr=BASE_ADDR; a push in the flush cycle is not stored.

Source files
------------

// File: rtl/instr_encoder.sv
// Frost32 instruction encoder: packs decoded fields into 32-bit words, buffers them in a FIFO
// and streams them with incrementing word addresses. Build option: INSTR_ENCODER_DROP_BAD_EN.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_group,
    input  logic [3:0]               in_ra_index,
    input  logic [3:0]               in_rb_index,
    input  logic [3:0]               in_rc_index,
    input  logic [3:0]               in_opcode,
    input  logic [15:0]              in_imm_val,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [31:0]              out_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_sticky,
    input  logic                     err_clr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic          err_q, err_d;

    logic [31:0]   enc_word;
    logic          enc_bad;
    logic          push;
    logic          store;
    logic          pop;

    always_comb begin
        enc_word = 32'h0;
        enc_bad  = 1'b0;
        case (in_group)
            4'd0, 4'd3, 4'd4: enc_word = {in_group, in_ra_index, in_rb_index, in_rc_index,
                                          12'h000, in_opcode};
            4'd1, 4'd2:       enc_word = {in_group, in_ra_index, in_rb_index, in_opcode,
                                          in_imm_val};
            4'd5: begin
                enc_word = {in_group, in_ra_index, in_rb_index, in_rc_index, in_opcode,
                            in_imm_val[11:0]};
                enc_bad  = (in_imm_val[15:12] != {4{in_imm_val[11]}});
            end
            default: begin
                enc_word = 32'h0;
                enc_bad  = 1'b1;
            end
        endcase
    end

    assign in_ready = (count_q < DEPTH_C);
    assign push     = in_valid & in_ready;
    assign pop      = (count_q != '0) & out_ready;
`ifdef INSTR_ENCODER_DROP_BAD_EN
    // Malformed words complete the handshake but never occupy a FIFO slot.
    assign store    = push & ~enc_bad;
`else
    assign store    = push;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        err_d    = err_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            addr_d   = BASE_ADDR;
            err_d    = 1'b0;
        end else begin
            if (store) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                addr_d   = addr_q + 32'd4;
            end
            case ({store, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (err_clr) begin
                err_d = 1'b0;
            end
            // A malformed push in the same cycle as err_clr keeps the flag set.
            if (push && enc_bad) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE_ADDR;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && store) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign out_addr   = addr_q;
    assign count      = count_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder; one task per scenario, wrap-around base address.
module tb_instr_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, err_sticky, err_clr;
    logic [3:0]  in_group, in_ra_index, in_rb_index, in_rc_index, in_opcode;
    logic [15:0] in_imm_val;
    logic [31:0] out_data, out_addr;
    logic [2:0]  count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr;
    logic [31:0] exp_word;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_group(in_group), .in_ra_index(in_ra_index), .in_rb_index(in_rb_index),
        .in_rc_index(in_rc_index), .in_opcode(in_opcode), .in_imm_val(in_imm_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .count(count), .err_sticky(err_sticky), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_f(input logic [3:0] g, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rc, input logic [3:0] op, input logic [15:0] imm);
        in_group = g; in_ra_index = ra; in_rb_index = rb;
        in_rc_index = rc; in_opcode = op; in_imm_val = imm;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        exp_addr = BASE;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
        checks++; if (out_addr !== BASE) begin errors++; $display("FAIL reset_addr got %h want %h", out_addr, BASE); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_sticky); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
        $display("reset: count=%0d addr=%h", count, out_addr);
    endtask

    task automatic test_basic();
        out_ready = 1'b1; in_valid = 1'b1;
        set_f(4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 16'hAAAA); cyc();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0123_0005) begin errors++; $display("FAIL g0_data got %h want 01230005", out_data); end
        checks++; if (out_addr !== exp_addr) begin errors++; $display("FAIL g0_addr got %h want %h", out_addr, exp_addr); end
        $display("basic: g0 word=%h addr=%h", out_data, out_addr);
        set_f(4'd1, 4'd4, 4'd5, 4'd9, 4'd2, 16'hBEEF); cyc();
        exp_addr += 4;
        checks++; if (out_data !== 32'h1452_BEEF) begin errors++; $display("FAIL g1_data got %h want 1452beef", out_data); end
        checks++; if (out_addr !== exp_addr || count !== 3'd1) begin errors++; $display("FAIL g1_addr got %h/%0d want %h/1", out_addr, count, exp_addr); end
        $display("basic: g1 word=%h addr=%h", out_data, out_addr);
        in_valid = 1'b0; cyc(); exp_addr += 4;
        checks++; if (count !== 3'd0 || err_sticky !== 1'b0) begin errors++; $display("FAIL basic_end got cnt=%0d err=%b want 0/0", count, err_sticky); end
    endtask

    task automatic test_ldst();
        out_ready = 1'b0; in_valid = 1'b1;
        set_f(4'd5, 4'd1, 4'd2, 4'd3, 4'd6, 16'hFFF8); cyc();
        checks++; if (out_data !== 32'h5123_6FF8 || err_sticky !== 1'b0) begin errors++; $display("FAIL ld_ok got %h err=%b want 51236ff8/0", out_data, err_sticky); end
        $display("ldst: word=%h err=%b", out_data, err_sticky);
        set_f(4'd5, 4'd1, 4'd2, 4'd3, 4'd6, 16'h0800); cyc(); in_valid = 1'b0;
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL ld_bad_err got %b want 1", err_sticky); end
`ifndef INSTR_ENCODER_DROP_BAD_EN
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL ld_bad_cnt got %0d want 2", count); end
        out_ready = 1'b1; cyc(); exp_addr += 4;
        checks++; if (out_data !== 32'h5123_6800 || out_addr !== exp_addr) begin errors++; $display("FAIL ld_bad_data got %h@%h want 51236800@%h", out_data, out_addr, exp_addr); end
        $display("ldst: bad word=%h addr=%h", out_data, out_addr);
        cyc(); exp_addr += 4;
`else
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL ld_bad_cnt got %0d want 1", count); end
        out_ready = 1'b1; cyc(); exp_addr += 4;
`endif
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL ld_drain got %0d want 0", count); end
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL err_clr got %b want 0", err_sticky); end
        $display("ldst: after err_clr err=%b", err_sticky);
    endtask

    task automatic test_bad_group();
        out_ready = 1'b0; in_valid = 1'b1;
        set_f(4'd9, 4'hF, 4'hE, 4'hD, 4'hC, 16'h1234); cyc(); in_valid = 1'b0;
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL g9_err got %b want 1", err_sticky); end
`ifndef INSTR_ENCODER_DROP_BAD_EN
        checks++; if (count !== 3'd1 || out_data !== 32'h0) begin errors++; $display("FAIL g9_nop got %h cnt=%0d want 0/1", out_data, count); end
`else
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL g9_drop got cnt=%0d want 0", count); end
`endif
        $display("bad_group: word=%h count=%0d err=%b", out_data, count, err_sticky);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        in_valid = 1'b1; err_clr = 1'b1; cyc(); in_valid = 1'b0; err_clr = 1'b0;
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL set_wins got %b want 1", err_sticky); end
        flush = 1'b1; cyc(); flush = 1'b0; exp_addr = BASE;
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            set_f(4'd0, 4'd1, 4'd2, 4'(i), 4'(i), 16'h0); in_valid = 1'b1;
            checks++; if (in_ready !== (i < DEPTH)) begin errors++; $display("FAIL full_ready[%0d] got %b want %b", i, in_ready, (i < DEPTH)); end
            cyc();
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'(DEPTH) || out_data !== 32'h0120_0000) begin errors++; $display("FAIL full_state got cnt=%0d %h want %0d 01200000", count, out_data, DEPTH); end
        cyc();
        checks++; if (out_data !== 32'h0120_0000 || out_addr !== exp_addr) begin errors++; $display("FAIL full_stable got %h@%h", out_data, out_addr); end
        $display("full: count=%0d head=%h", count, out_data);
        out_ready = 1'b1; in_valid = 1'b1; set_f(4'd0, 4'd7, 4'd7, 4'd7, 4'd7, 16'h0);
        for (int i = 0; i < DEPTH; i++) begin
            exp_word = 32'h0120_0000 | (32'(i) << 16) | 32'(i);
            checks++; if (out_data !== exp_word || out_addr !== exp_addr) begin errors++; $display("FAIL drain[%0d] got %h@%h want %h@%h", i, out_data, out_addr, exp_word, exp_addr); end
            $display("full: drain word=%h addr=%h", out_data, out_addr);
            cyc(); in_valid = 1'b0; exp_addr += 4;
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_blocked got %0d want 0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] k;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            k = 8'(i); set_f(4'd1, k[3:0], 4'd0, 4'd0, 4'd1, {8'h0, k}); cyc();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            k = 8'(i + 2); set_f(4'd1, k[3:0], 4'd0, 4'd0, 4'd1, {8'h0, k});
            k = 8'(i);
            exp_word = {4'h1, k[3:0], 4'h0, 4'h1, 8'h0, k};
            checks++; if (count !== 3'd2 || out_data !== exp_word || out_addr !== exp_addr) begin errors++; $display("FAIL b2b[%0d] got cnt=%0d %h@%h want 2 %h@%h", i, count, out_data, out_addr, exp_word, exp_addr); end
            $display("b2b: word=%h addr=%h count=%0d", out_data, out_addr, count);
            cyc(); exp_addr += 4;
        end
        in_valid = 1'b0; cyc(); cyc(); exp_addr += 8;
        checks++; if (count !== 3'd0 || out_addr !== exp_addr) begin errors++; $display("FAIL b2b_end got cnt=%0d @%h want 0 @%h", count, out_addr, exp_addr); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush(input bit use_reset);
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin set_f(4'd0, 4'd1, 4'd1, 4'd1, 4'(i), 16'h0); cyc(); end
        set_f(4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0); cyc();
        set_f(4'd0, 4'd3, 4'd3, 4'd3, 4'd3, 16'h0);
        if (use_reset) rst_n = 1'b0; else flush = 1'b1;
        cyc(); rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; exp_addr = BASE;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL clr%0d_empty got cnt=%0d v=%b want 0/0", use_reset, count, out_valid); end
        checks++; if (out_addr !== BASE || err_sticky !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL clr%0d_state got %h err=%b rdy=%b", use_reset, out_addr, err_sticky, in_ready); end
        cyc();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL clr%0d_push got %0d want 0", use_reset, count); end
        $display("clear(reset=%0d): count=%0d addr=%h", use_reset, count, out_addr);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        set_f(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0);
        exp_addr = BASE; exp_word = 32'h0;
        cyc();
        test_reset();
        test_basic();
        test_ldst();
        test_bad_group();
        test_full();
        test_back_to_back();
        test_flush(1'b0);
        test_flush(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
